// File: rtl/lobster_pkg.sv
// Shared types for the lobster data-bus arbiter: access sizes, bus owners, FSM states,
// and the byte-enable helper used by the lane aligner.
package lobster_pkg;

    typedef enum logic [1:0] {
        MEM_8  = 2'd0,
        MEM_16 = 2'd1,
        MEM_32 = 2'd2,
        MEM_64 = 2'd3
    } mem_size_e;

    typedef enum logic [1:0] {
        DBUS_NOP   = 2'd0,
        DBUS_FETCH = 2'd1,
        DBUS_LOAD  = 2'd2,
        DBUS_STORE = 2'd3
    } dbus_owner_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_ACK  = 2'd2
    } dbus_state_e;

    // Counter widths cover the largest legal TIMEOUT (255) and STARVE_LIMIT (15).
    localparam int TMO_W    = 8;
    localparam int STARVE_W = 4;

    function automatic logic [7:0] byte_enable(input mem_size_e size, input logic [2:0] off);
        logic [7:0] mask;
        case (size)
            MEM_8:   mask = 8'h01;
            MEM_16:  mask = 8'h03;
            MEM_32:  mask = 8'h0F;
            default: mask = 8'hFF;
        endcase
        return mask << off;
    endfunction

endpackage

// File: rtl/lobster_dbus_arbiter_if.sv
// Requester and SRAM signals of the lobster data-bus arbiter.
// slave = the arbiter itself, master = the pipeline/SRAM environment around it.
interface lobster_dbus_arbiter_if #(
    parameter int ADDR_WIDTH = 36
);
    logic                  fetch_req;
    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic                  fetch_ack;
    logic [63:0]           fetch_data;

    logic                  ld_req;
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic [1:0]            ld_size;
    logic                  ld_ack;
    logic [63:0]           ld_data;

    logic                  st_req;
    logic [ADDR_WIDTH-1:0] st_addr;
    logic [1:0]            st_size;
    logic [63:0]           st_data;
    logic                  st_ack;

    logic                  err;
    logic                  busy;

    logic                  mem_ce;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [7:0]            mem_be;
    logic [63:0]           mem_wdata;
    logic                  mem_rdy;
    logic [63:0]           mem_rdata;

    modport slave (
        input  fetch_req, fetch_addr,
        input  ld_req, ld_addr, ld_size,
        input  st_req, st_addr, st_size, st_data,
        input  mem_rdy, mem_rdata,
        output fetch_ack, fetch_data, ld_ack, ld_data, st_ack, err, busy,
        output mem_ce, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport master (
        output fetch_req, fetch_addr,
        output ld_req, ld_addr, ld_size,
        output st_req, st_addr, st_size, st_data,
        output mem_rdy, mem_rdata,
        input  fetch_ack, fetch_data, ld_ack, ld_data, st_ack, err, busy,
        input  mem_ce, mem_we, mem_addr, mem_be, mem_wdata
    );

endinterface

// File: rtl/lobster_dbus_lane.sv
// Byte-lane aligner: byte enables, store-data shift, load extraction with zero-extension,
// and the misalignment flag for one 8-byte SRAM word.
module lobster_dbus_lane
    import lobster_pkg::*;
(
    input  mem_size_e   i_size,
    input  logic [2:0]  i_off,
    input  logic [63:0] i_wdata,
    input  logic [63:0] i_rdata,
    output logic [7:0]  o_be,
    output logic [63:0] o_wdata,
    output logic [63:0] o_rdata,
    output logic        o_misaligned
);

    logic [5:0]  w_shamt;
    logic [63:0] w_rmask;

    assign w_shamt = {i_off, 3'b000};

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        o_misaligned = 1'b0;
        w_rmask      = '1;
        case (i_size)
            MEM_8: begin
                w_rmask = 64'h0000_0000_0000_00FF;
            end
            MEM_16: begin
                o_misaligned = i_off[0];
                w_rmask      = 64'h0000_0000_0000_FFFF;
            end
            MEM_32: begin
                o_misaligned = |i_off[1:0];
                w_rmask      = 64'h0000_0000_FFFF_FFFF;
            end
            default: begin
                o_misaligned = |i_off;
            end
        endcase
    end

    assign o_be    = byte_enable(i_size, i_off);
    assign o_wdata = i_wdata << w_shamt;
    assign o_rdata = (i_rdata >> w_shamt) & w_rmask;

endmodule

// File: rtl/lobster_dbus_arbiter.sv
// Single-outstanding SRAM port arbiter for fetch/load/store with lane alignment,
// misalignment rejection and an SRAM ready timeout. Every output comes straight from a flop.
module lobster_dbus_arbiter
    import lobster_pkg::*;
#(
    parameter int ADDR_WIDTH   = 36,
    parameter int TIMEOUT      = 255,
    parameter int STARVE_LIMIT = 4
) (
    input logic                   clk,
    input logic                   rst,
    lobster_dbus_arbiter_if.slave bus
);

    dbus_state_e           r_state, w_state_nxt;
    dbus_owner_e           r_owner, w_owner_nxt;
    dbus_owner_e           w_grant, w_done;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
    mem_size_e             r_size, w_size_nxt;
    logic [63:0]           r_sdata, w_sdata_nxt;

    logic                  r_mem_ce, w_mem_ce_nxt;
    logic                  r_mem_we, w_mem_we_nxt;
    logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [7:0]            r_mem_be, w_mem_be_nxt;
    logic [63:0]           r_mem_wdata, w_mem_wdata_nxt;

    logic                  r_fetch_ack, w_fetch_ack_nxt;
    logic                  r_ld_ack, w_ld_ack_nxt;
    logic                  r_st_ack, w_st_ack_nxt;
    logic                  r_err, w_err_nxt;
    logic                  r_busy, w_busy_nxt;
    logic [63:0]           r_fetch_data, w_fetch_data_nxt;
    logic [63:0]           r_ld_data, w_ld_data_nxt;

    logic [TMO_W-1:0]      r_tmo_cnt, w_tmo_cnt_nxt;
    logic [STARVE_W-1:0]   r_starve_cnt, w_starve_cnt_nxt;
    logic                  w_capture;

    logic [7:0]            w_lane_be;
    logic [63:0]           w_lane_wdata;
    logic [63:0]           w_lane_rdata;
    logic                  w_misaligned;

    // Arbitration and payload latch; only IDLE grants, so outside IDLE the payload holds.
    always_comb begin
        w_grant          = DBUS_NOP;
        w_owner_nxt      = r_owner;
        w_addr_nxt       = r_addr;
        w_size_nxt       = r_size;
        w_sdata_nxt      = r_sdata;
        w_starve_cnt_nxt = r_starve_cnt;

        if (r_state == ST_IDLE) begin
            if (bus.fetch_req && (r_starve_cnt >= STARVE_W'(STARVE_LIMIT))) w_grant = DBUS_FETCH;
            else if (bus.st_req)                                            w_grant = DBUS_STORE;
            else if (bus.ld_req)                                            w_grant = DBUS_LOAD;
            else if (bus.fetch_req)                                         w_grant = DBUS_FETCH;
        end

        case (w_grant)
            DBUS_FETCH: begin
                w_addr_nxt  = bus.fetch_addr;
                w_size_nxt  = MEM_64;
                w_sdata_nxt = '0;
            end
            DBUS_LOAD: begin
                w_addr_nxt  = bus.ld_addr;
                w_size_nxt  = mem_size_e'(bus.ld_size);
                w_sdata_nxt = '0;
            end
            DBUS_STORE: begin
                w_addr_nxt  = bus.st_addr;
                w_size_nxt  = mem_size_e'(bus.st_size);
                w_sdata_nxt = bus.st_data;
            end
            default: ;
        endcase
        if (w_grant != DBUS_NOP) w_owner_nxt = w_grant;

        if (!bus.fetch_req || (w_grant == DBUS_FETCH)) w_starve_cnt_nxt = '0;
        else if (w_grant != DBUS_NOP)                  w_starve_cnt_nxt = r_starve_cnt + 1'b1;
    end

    // Fed from the payload flops' D side: in IDLE it sees the incoming winner so be/wdata/err
    // register together with the payload; in BUS it equals the held payload for read extraction.
    lobster_dbus_lane u_lane (
        .i_size       (w_size_nxt),
        .i_off        (w_addr_nxt[2:0]),
        .i_wdata      (w_sdata_nxt),
        .i_rdata      (bus.mem_rdata),
        .o_be         (w_lane_be),
        .o_wdata      (w_lane_wdata),
        .o_rdata      (w_lane_rdata),
        .o_misaligned (w_misaligned)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_mem_ce_nxt    = r_mem_ce;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_be_nxt    = r_mem_be;
        w_mem_wdata_nxt = r_mem_wdata;
        w_tmo_cnt_nxt   = r_tmo_cnt;
        w_err_nxt       = 1'b0;
        w_done          = DBUS_NOP;
        w_capture       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_grant != DBUS_NOP) begin
                    if (w_misaligned) begin
                        w_state_nxt = ST_ACK;
                        w_done      = w_grant;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_state_nxt     = ST_BUS;
                        w_mem_ce_nxt    = 1'b1;
                        w_mem_we_nxt    = (w_grant == DBUS_STORE);
                        w_mem_addr_nxt  = {w_addr_nxt[ADDR_WIDTH-1:3], 3'b000};
                        w_mem_be_nxt    = w_lane_be;
                        w_mem_wdata_nxt = (w_grant == DBUS_STORE) ? w_lane_wdata : '0;
                        w_tmo_cnt_nxt   = '0;
                    end
                end
            end
            ST_BUS: begin
                if (bus.mem_rdy) begin
                    w_state_nxt  = ST_ACK;
                    w_mem_ce_nxt = 1'b0;
                    w_mem_we_nxt = 1'b0;
                    w_done       = r_owner;
                    w_capture    = 1'b1;
                end else if (r_tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                    w_state_nxt  = ST_ACK;
                    w_mem_ce_nxt = 1'b0;
                    w_mem_we_nxt = 1'b0;
                    w_done       = r_owner;
                    w_err_nxt    = 1'b1;
                end else begin
                    w_tmo_cnt_nxt = r_tmo_cnt + 1'b1;
                end
            end
            ST_ACK: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_fetch_ack_nxt  = (w_done == DBUS_FETCH);
        w_ld_ack_nxt     = (w_done == DBUS_LOAD);
        w_st_ack_nxt     = (w_done == DBUS_STORE);
        w_busy_nxt       = (w_state_nxt != ST_IDLE);
        w_fetch_data_nxt = r_fetch_data;
        w_ld_data_nxt    = r_ld_data;
        // A failed transaction returns zero data.
        if (w_done == DBUS_FETCH) w_fetch_data_nxt = w_capture ? bus.mem_rdata : '0;
        if (w_done == DBUS_LOAD)  w_ld_data_nxt    = w_capture ? w_lane_rdata  : '0;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_owner      <= DBUS_NOP;
            r_addr       <= '0;
            r_size       <= MEM_8;
            r_sdata      <= '0;
            r_mem_ce     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_be     <= '0;
            r_mem_wdata  <= '0;
            r_fetch_ack  <= 1'b0;
            r_ld_ack     <= 1'b0;
            r_st_ack     <= 1'b0;
            r_err        <= 1'b0;
            r_busy       <= 1'b0;
            r_fetch_data <= '0;
            r_ld_data    <= '0;
            r_tmo_cnt    <= '0;
            r_starve_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_addr       <= w_addr_nxt;
            r_size       <= w_size_nxt;
            r_sdata      <= w_sdata_nxt;
            r_mem_ce     <= w_mem_ce_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_be     <= w_mem_be_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_fetch_ack  <= w_fetch_ack_nxt;
            r_ld_ack     <= w_ld_ack_nxt;
            r_st_ack     <= w_st_ack_nxt;
            r_err        <= w_err_nxt;
            r_busy       <= w_busy_nxt;
            r_fetch_data <= w_fetch_data_nxt;
            r_ld_data    <= w_ld_data_nxt;
            r_tmo_cnt    <= w_tmo_cnt_nxt;
            r_starve_cnt <= w_starve_cnt_nxt;
        end
    end

    assign bus.mem_ce     = r_mem_ce;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_be     = r_mem_be;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.fetch_ack  = r_fetch_ack;
    assign bus.ld_ack     = r_ld_ack;
    assign bus.st_ack     = r_st_ack;
    assign bus.err        = r_err;
    assign bus.busy       = r_busy;
    assign bus.fetch_data = r_fetch_data;
    assign bus.ld_data    = r_ld_data;

endmodule

// File: tb/tb_lobster_dbus_arbiter.sv
// Directed bench for lobster_dbus_arbiter: load/store alignment, arbitration order,
// fetch starvation, misalignment, timeout and reset mid-transaction.
module tb_lobster_dbus_arbiter;

    localparam int AW     = 36;
    localparam int TMO    = 8;
    localparam int STARVE = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lobster_dbus_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

    lobster_dbus_arbiter #(
        .ADDR_WIDTH   (AW),
        .TIMEOUT      (TMO),
        .STARVE_LIMIT (STARVE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge, half a cycle from the active edge.
    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int st_c, ld_c, f_c, n_st, n_ld, n_ce;
        logic [63:0] cap_ld, cap_f;
        logic        cap_err;

        rst            = 1'b1;
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = '0;
        bus.ld_req     = 1'b0;
        bus.ld_addr    = '0;
        bus.ld_size    = 2'd0;
        bus.st_req     = 1'b0;
        bus.st_addr    = '0;
        bus.st_size    = 2'd0;
        bus.st_data    = '0;
        bus.mem_rdy    = 1'b0;
        bus.mem_rdata  = '0;
        repeat (3) step();

        check("rst_busy",   64'(bus.busy),     64'd0);
        check("rst_ce",     64'(bus.mem_ce),   64'd0);
        check("rst_be",     64'(bus.mem_be),   64'd0);
        check("rst_addr",   64'(bus.mem_addr), 64'd0);
        check("rst_acks",   64'({bus.fetch_ack, bus.ld_ack, bus.st_ack}), 64'd0);
        rst = 1'b0;
        step();

        // Test 1: byte load at 0x1003, ready on the second bus cycle.
        bus.ld_req  = 1'b1;
        bus.ld_addr = 36'h1003;
        bus.ld_size = 2'd0;
        step();
        check("t1_ce",   64'(bus.mem_ce),   64'd1);
        check("t1_addr", 64'(bus.mem_addr), 64'h1000);
        check("t1_be",   64'(bus.mem_be),   64'h08);
        check("t1_we",   64'(bus.mem_we),   64'd0);
        check("t1_busy", 64'(bus.busy),     64'd1);
        step();
        bus.mem_rdy   = 1'b1;
        bus.mem_rdata = 64'h1122_3344_5566_7788;
        step();
        check("t1_ack",   64'(bus.ld_ack), 64'd1);
        check("t1_data",  bus.ld_data,     64'h55);
        check("t1_err",   64'(bus.err),    64'd0);
        check("t1_ce_dn", 64'(bus.mem_ce), 64'd0);
        bus.ld_req  = 1'b0;
        bus.mem_rdy = 1'b0;
        step();
        check("t1_ack_pulse", 64'(bus.ld_ack), 64'd0);
        check("t1_data_hold", bus.ld_data,     64'h55);
        check("t1_idle",      64'(bus.busy),   64'd0);

        // Test 2: word store at 0x2004, ready immediately.
        bus.st_req  = 1'b1;
        bus.st_addr = 36'h2004;
        bus.st_size = 2'd2;
        bus.st_data = 64'hDEAD_BEEF;
        step();
        check("t2_be",    64'(bus.mem_be), 64'hF0);
        check("t2_wdata", bus.mem_wdata,   64'hDEAD_BEEF_0000_0000);
        check("t2_we",    64'(bus.mem_we), 64'd1);
        check("t2_ce",    64'(bus.mem_ce), 64'd1);
        bus.mem_rdy = 1'b1;
        step();
        check("t2_ack",    64'(bus.st_ack), 64'd1);
        check("t2_err",    64'(bus.err),    64'd0);
        check("t2_we_dn",  64'(bus.mem_we), 64'd0);
        check("t2_no_ld",  64'(bus.ld_ack), 64'd0);
        bus.st_req  = 1'b0;
        bus.mem_rdy = 1'b0;
        step();
        check("t2_ack_pulse", 64'(bus.st_ack), 64'd0);

        // Test 3: simultaneous requests, order store, load, fetch, acks 3 cycles apart.
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 36'h100;
        bus.ld_req     = 1'b1;
        bus.ld_addr    = 36'h208;
        bus.ld_size    = 2'd3;
        bus.st_req     = 1'b1;
        bus.st_addr    = 36'h300;
        bus.st_size    = 2'd3;
        bus.st_data    = 64'h0123_4567_89AB_CDEF;
        bus.mem_rdy    = 1'b1;
        bus.mem_rdata  = 64'hCAFE_F00D_1234_5678;
        st_c = -1; ld_c = -1; f_c = -1;
        cap_ld = '0; cap_f = '0;
        for (int c = 1; c <= 15; c++) begin
            step();
            if (bus.st_ack && st_c < 0) begin
                st_c = c;
                bus.st_req = 1'b0;
            end
            if (bus.ld_ack && ld_c < 0) begin
                ld_c = c;
                cap_ld = bus.ld_data;
                bus.ld_req = 1'b0;
            end
            if (bus.fetch_ack && f_c < 0) begin
                f_c = c;
                cap_f = bus.fetch_data;
                bus.fetch_req = 1'b0;
            end
        end
        bus.mem_rdy = 1'b0;
        check("t3_st_cycle", 64'(st_c), 64'd2);
        check("t3_ld_cycle", 64'(ld_c), 64'd5);
        check("t3_f_cycle",  64'(f_c),  64'd8);
        check("t3_ld_data",  cap_ld,    64'hCAFE_F00D_1234_5678);
        check("t3_f_data",   cap_f,     64'hCAFE_F00D_1234_5678);

        // Test 4: fetch held while store and load keep requesting; fetch wins the 5th arbitration.
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 36'h108;
        bus.st_req     = 1'b1;
        bus.st_addr    = 36'h400;
        bus.st_size    = 2'd3;
        bus.ld_req     = 1'b1;
        bus.ld_addr    = 36'h500;
        bus.ld_size    = 2'd3;
        bus.mem_rdy    = 1'b1;
        n_st = 0; n_ld = 0; f_c = -1;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (f_c < 0) begin
                if (bus.st_ack) n_st++;
                if (bus.ld_ack) n_ld++;
                if (bus.fetch_ack) begin
                    f_c = c;
                    bus.fetch_req = 1'b0;
                    bus.st_req    = 1'b0;
                    bus.ld_req    = 1'b0;
                end
            end
        end
        bus.mem_rdy = 1'b0;
        check("t4_st_wins", 64'(n_st), 64'd4);
        check("t4_ld_wins", 64'(n_ld), 64'd0);
        check("t4_f_cycle", 64'(f_c),  64'd14);

        // Test 5a: misaligned halfword load, ack with err one cycle later and no bus cycle.
        bus.ld_req  = 1'b1;
        bus.ld_addr = 36'h3001;
        bus.ld_size = 2'd1;
        step();
        check("t5a_ack",  64'(bus.ld_ack), 64'd1);
        check("t5a_err",  64'(bus.err),    64'd1);
        check("t5a_ce",   64'(bus.mem_ce), 64'd0);
        check("t5a_busy", 64'(bus.busy),   64'd1);
        bus.ld_req = 1'b0;
        step();
        check("t5a_ack_pulse", 64'(bus.ld_ack), 64'd0);
        check("t5a_err_pulse", 64'(bus.err),    64'd0);
        check("t5a_idle",      64'(bus.busy),   64'd0);

        // Test 5b: fetch with ready stuck low times out after TIMEOUT bus cycles.
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 36'h4000;
        f_c = -1; n_ce = 0;
        cap_f = '1; cap_err = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (f_c < 0) begin
                if (bus.mem_ce) n_ce++;
                if (bus.fetch_ack) begin
                    f_c = c;
                    cap_f = bus.fetch_data;
                    cap_err = bus.err;
                    bus.fetch_req = 1'b0;
                end
            end
        end
        check("t5b_f_cycle", 64'(f_c),     64'd9);
        check("t5b_ce_cyc",  64'(n_ce),    64'd8);
        check("t5b_data",    cap_f,        64'd0);
        check("t5b_err",     64'(cap_err), 64'd1);

        // Test 6: reset during a bus cycle abandons the load; a later store completes.
        bus.ld_req  = 1'b1;
        bus.ld_addr = 36'h5000;
        bus.ld_size = 2'd3;
        step();
        check("t6_ce_pre", 64'(bus.mem_ce), 64'd1);
        rst = 1'b1;
        bus.ld_req = 1'b0;
        step();
        check("t6_busy",  64'(bus.busy),      64'd0);
        check("t6_ce",    64'(bus.mem_ce),    64'd0);
        check("t6_we",    64'(bus.mem_we),    64'd0);
        check("t6_addr",  64'(bus.mem_addr),  64'd0);
        check("t6_be",    64'(bus.mem_be),    64'd0);
        check("t6_wdata", bus.mem_wdata,      64'd0);
        check("t6_acks",  64'({bus.fetch_ack, bus.ld_ack, bus.st_ack}), 64'd0);
        check("t6_err",   64'(bus.err),       64'd0);
        check("t6_ldd",   bus.ld_data,        64'd0);
        check("t6_fd",    bus.fetch_data,     64'd0);
        rst = 1'b0;
        step();
        check("t6_no_ack", 64'(bus.ld_ack), 64'd0);
        bus.st_req  = 1'b1;
        bus.st_addr = 36'h6001;
        bus.st_size = 2'd0;
        bus.st_data = 64'hAB;
        bus.mem_rdy = 1'b1;
        step();
        check("t6_st_be",    64'(bus.mem_be), 64'h02);
        check("t6_st_wdata", bus.mem_wdata,   64'hAB00);
        check("t6_st_we",    64'(bus.mem_we), 64'd1);
        step();
        check("t6_st_ack", 64'(bus.st_ack), 64'd1);
        check("t6_st_err", 64'(bus.err),    64'd0);
        bus.st_req  = 1'b0;
        bus.mem_rdy = 1'b0;
        step();
        check("t6_st_idle", 64'(bus.busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
